uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter serialising one byte per frame onto a single line. It is the transmit-side counterpart of the team's UART receiver and uses the same configuration inputs: `par_enable`, `par_type` and `prescale`. The frame is a start bit, 8 data bits LSB first, an optional parity bit and a stop bit. It sits between a byte-producing host and the serial pin, and pairs with the receiver in loopback benches.

Parameters:
- DATA_WIDTH, 8, payload bits per frame. Fixed at 8 for protocol compatibility; the parameter exists for bench reuse only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled on acceptance.
- data_valid  input  1  host request; accepted when high and busy low.
- par_enable  input  1  1 = insert parity bit after data.
- par_type  input  1  0 = even parity, 1 = odd parity.
- prescale  input  8  clk cycles per serial bit; 0 is treated as 1.
- tx_out  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the last stop-bit cycle completes.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, tx_out=1, busy=0, tx_done=0, all counters 0. This applies mid-frame too: the line returns high on the edge where rst is sampled, the frame is abandoned, and no tx_done is generated.
- Acceptance: in IDLE with data_valid=1, the next edge performs all of the following:
  - latches data_in, par_enable, par_type and prescale into shadow registers;
  - moves to START;
  - sets busy=1 and tx_out=0.
- Input changes after acceptance do not affect the frame in flight. data_valid while busy=1 is ignored; there is no queuing.
- States: IDLE -> START -> DATA -> (PARITY if latched par_enable) -> STOP -> IDLE.
- Bit timing: a cycle counter runs 0..P-1, where P = max(latched prescale, 1). Each state holds tx_out for exactly P cycles, and the state advances when the counter equals P-1, with the counter wrapping to 0.
- DATA: a 3-bit index runs 0..7 and tx_out = shadow[index]. Advance out of DATA after index 7's last cycle.
- PARITY: tx_out = ^shadow XOR par_type, i.e. even makes the total count of 1s even.
- STOP: tx_out=1. On its last cycle, tx_done pulses for exactly 1 cycle. On the following edge the state is IDLE and busy=0.
- Frame length is 10·P cycles without parity and 11·P with parity, measured from the first tx_out=0 cycle to the end of stop.
- Back-to-back: busy is low only in IDLE, so consecutive frames are separated by at least 1 idle-high cycle. A data_valid held high continuously therefore yields frames with a 1-cycle gap.
- tx_out is driven directly from a register, with no combinational path from inputs to outputs.
- Latency: data_valid accepted at edge N; the start bit is visible from N+1.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: a second STOP bit period is transmitted (tx_out=1 for 2·P cycles). Frame length becomes 11·P without parity and 12·P with parity. tx_done pulses on the last cycle of the second stop bit.
- Undefined: a single stop bit, exactly as described in Behaviour.

Test Plan:
1. Even parity, 0xA5: rst, then prescale=8, par_enable=1, par_type=0, data_in=0xA5 with a 1-cycle data_valid.
   - Required tx_out bit sequence: 0,1,0,1,0,0,1,0,1,0,1, each bit held 8 cycles.
   - busy is high for 88 cycles, and tx_done pulses in cycle 88.
2. Odd vs even parity, 0x01: par_type=1 gives parity bit 0; rerun with par_type=0 and the parity bit is 1.
   - No parity, 0xFF, prescale=4: frame 0,1×8,1, 40 cycles, tx_done once.
3. Ignore while busy: assert data_valid with 0x3C mid-frame of 0x55.
   - Only 0x55 is transmitted and 0x3C is dropped.
   - Holding data_valid with 0x3C after busy falls sends 0x3C with exactly 1 idle-high cycle between frames.
4. Reset mid-frame: assert rst during data bit 3.
   - tx_out=1, busy=0 and tx_done=0 on the next edge, with no further transitions.
   - A subsequent request for 0x81 transmits cleanly.
5. Prescale edge cases:
   - prescale=0 and prescale=1 each give 1 cycle per bit, a 10-cycle frame for 0x00 with no parity.
   - Changing prescale from 8 to 16 mid-frame leaves the current frame at 8 cycles per bit.
6. Loopback: connect tx_out to the UART receiver, prescale=8, par_enable=1, par_type=1, and send 256 bytes 0x00..0xFF.
   - Every receiver output byte matches the byte sent, and the receiver's data_valid fires once per byte.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to transmit two stop-bit periods per frame.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  par_enable,
  input  logic                  par_type,
  input  logic [7:0]            prescale,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

`ifdef UART_TX_TWO_STOP_EN
  localparam logic TWO_STOP = 1'b1;
`else
  localparam logic TWO_STOP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] shadow_r;
  logic                  par_en_r;
  logic                  par_type_r;
  logic [7:0]            p_r;
  logic [7:0]            cnt_r;
  logic [IW-1:0]         idx_r;
  logic                  bit_end_s;
  logic                  enter_done_s;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign bit_end_s = (cnt_r == (p_r - 8'd1));
  // Entering the final stop period with P=1 makes its first cycle also its last.
  assign enter_done_s = (p_r == 8'd1);

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shadow_r   <= '0;
      par_en_r   <= 1'b0;
      par_type_r <= 1'b0;
      p_r        <= 8'd1;
      cnt_r      <= 8'd0;
      idx_r      <= '0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 8'd0;
          idx_r <= '0;
          if (data_valid) begin
            shadow_r   <= data_in;
            par_en_r   <= par_enable;
            par_type_r <= par_type;
            p_r        <= (prescale == 8'd0) ? 8'd1 : prescale;
            state_r    <= START;
            busy       <= 1'b1;
            tx_out     <= 1'b0;
          end else begin
            busy   <= 1'b0;
            tx_out <= 1'b1;
          end
        end
        START: begin
          if (bit_end_s) begin
            cnt_r   <= 8'd0;
            state_r <= DATA;
            tx_out  <= shadow_r[0];
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            cnt_r <= 8'd0;
            if (idx_r == LAST_IDX) begin
              idx_r <= '0;
              if (par_en_r) begin
                state_r <= PARITY;
                tx_out  <= parity_bit(shadow_r, par_type_r);
              end else begin
                state_r <= STOP;
                tx_out  <= 1'b1;
                tx_done <= enter_done_s & ~TWO_STOP;
              end
            end else begin
              idx_r  <= idx_r + IW'(1);
              tx_out <= shadow_r[idx_r + IW'(1)];
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            cnt_r   <= 8'd0;
            state_r <= STOP;
            tx_out  <= 1'b1;
            tx_done <= enter_done_s & ~TWO_STOP;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
`ifdef UART_TX_TWO_STOP_EN
        STOP: begin
          if (bit_end_s) begin
            cnt_r   <= 8'd0;
            state_r <= STOP2;
            tx_done <= enter_done_s;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        STOP2: begin
          if (bit_end_s) begin
            cnt_r   <= 8'd0;
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
            tx_done <= (cnt_r == (p_r - 8'd2));
          end
        end
`else
        STOP: begin
          if (bit_end_s) begin
            cnt_r   <= 8'd0;
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
            tx_done <= (cnt_r == (p_r - 8'd2));
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          cnt_r   <= 8'd0;
          idx_r   <= '0;
          busy    <= 1'b0;
          tx_out  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed test-plan frames plus random frames,
// checked cycle by cycle against a frame model built from the protocol rules.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       par_enable;
  logic       par_type;
  logic [7:0] prescale;
  logic       tx_out;
  logic       busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .par_enable (par_enable),
    .par_type   (par_type),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int frame_bits(input logic pe);
    return 9 + (pe ? 1 : 0) + NSTOP;
  endfunction

  // Bit k of the frame: 0 = start, 1..8 = data LSB first, then parity, then stop(s).
  function automatic logic model_bit(input logic [7:0] d, input logic pe, input logic pt, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && pe) return logic'(($countones(d) + (pt ? 1 : 0)) % 2);
    return 1'b1;
  endfunction

  // Observe one frame whose acceptance edge has just happened (or is the next edge).
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt, input int p,
                           input logic disturb, input logic [7:0] nd, input logic npe,
                           input logic npt, input logic [7:0] nps, output logic [15:0] seen);
    int   len;
    int   busy_len;
    int   done_cnt;
    int   done_pos;
    int   wave_err;
    logic idle_out;
    logic ended;
    len = frame_bits(pe) * p;
    busy_len = 0; done_cnt = 0; done_pos = 0; wave_err = 0;
    idle_out = 1'b0; ended = 1'b0; seen = '0;
    for (int c = 1; c <= len + 4 && !ended; c++) begin
      @(negedge clk);
      if (c == 1) data_valid = 1'b0;
      if (disturb && c == 3) begin
        data_in = nd; par_enable = npe; par_type = npt; prescale = nps; data_valid = 1'b1;
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_pos = c;
      end
      if (busy !== 1'b1) begin
        ended = 1'b1;
        idle_out = tx_out;
      end else begin
        busy_len++;
        if (tx_out !== model_bit(d, pe, pt, (c - 1) / p)) wave_err++;
        if ((c - 1) % p == p / 2 && (c - 1) / p < 16) seen[(c - 1) / p] = tx_out;
      end
    end
    check("busy_len", busy_len, len);
    check("done_cnt", done_cnt, 1);
    check("done_pos", done_pos, len);
    check("wave_err", wave_err, 0);
    check("idle_after", {31'd0, idle_out}, 1);
    check("rx_byte", {24'd0, seen[8:1]}, {24'd0, d});
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [7:0] ps,
                      output logic [15:0] seen);
    data_in = d; par_enable = pe; par_type = pt; prescale = ps; data_valid = 1'b1;
    run_frame(d, pe, pt, (ps == 8'd0) ? 1 : int'(ps), 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, seen);
  endtask

  initial begin
    logic [15:0] seen;
    logic [7:0]  rd;
    logic        rpe;
    logic        rpt;
    logic [7:0]  rps;
    int          viol;

    rst = 1'b1; data_valid = 1'b0; data_in = 8'd0;
    par_enable = 1'b0; par_type = 1'b0; prescale = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_tx_out", {31'd0, tx_out}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, tx_done}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Even parity 0xA5: 0,1,0,1,0,0,1,0,1,0,1 with the first bit in the LSB.
    send(8'hA5, 1'b1, 1'b0, 8'd8, seen);
    check("a5_seq", {16'd0, seen & 16'h07FF}, 32'd1354);

    send(8'h01, 1'b1, 1'b1, 8'd8, seen);
    check("odd_par_01", {31'd0, seen[9]}, 0);
    send(8'h01, 1'b1, 1'b0, 8'd8, seen);
    check("even_par_01", {31'd0, seen[9]}, 1);

    send(8'hFF, 1'b0, 1'b0, 8'd4, seen);

    // Request 0x3C mid-frame and hold it: dropped now, sent after one idle cycle.
    data_in = 8'h55; par_enable = 1'b0; par_type = 1'b0; prescale = 8'd8; data_valid = 1'b1;
    run_frame(8'h55, 1'b0, 1'b0, 8, 1'b1, 8'h3C, 1'b0, 1'b0, 8'd8, seen);
    run_frame(8'h3C, 1'b0, 1'b0, 8, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, seen);

    // Reset during data bit 3 (frame bit 4, cycles 33..40 at P=8).
    data_in = 8'hF0; par_enable = 1'b1; par_type = 1'b0; prescale = 8'd8; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (34) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_out", {31'd0, tx_out}, 1);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, tx_done}, 0);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) viol++;
    end
    check("post_rst_quiet", viol, 0);
    send(8'h81, 1'b0, 1'b0, 8'd8, seen);

    send(8'h00, 1'b0, 1'b0, 8'd0, seen);
    send(8'h00, 1'b0, 1'b0, 8'd1, seen);

    // Prescale 8 -> 16 mid-frame: current frame stays at 8, the next uses 16.
    data_in = 8'h5A; par_enable = 1'b0; par_type = 1'b0; prescale = 8'd8; data_valid = 1'b1;
    run_frame(8'h5A, 1'b0, 1'b0, 8, 1'b1, 8'hC3, 1'b1, 1'b1, 8'd16, seen);
    run_frame(8'hC3, 1'b1, 1'b1, 16, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, seen);

    for (int i = 0; i < 40; i++) begin
      rd  = 8'($urandom_range(0, 255));
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      rps = 8'($urandom_range(0, 5));
      send(rd, rpe, rpt, rps, seen);
    end

    // Loopback-style sweep decoded by the bench's mid-bit sampler.
    for (int b = 0; b < 256; b++) begin
      send(8'(b), 1'b1, 1'b1, 8'd8, seen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
